uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter OS_DIV, default 651, clk cycles per 16x-oversample tick (legal: >= 2).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (legal: 5..8).
REQ-003 Parameter PARITY_EN, default 0, 1 = parity bit appended after data.
REQ-004 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
REQ-005 Parameter STOP_BITS, default 1, stop bits transmitted (legal: 1..2).
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 tx_data  input  DATA_BITS  byte to send; sampled on handshake.
REQ-009 tx_valid  input  1  tx_data valid.
REQ-010 tx_ready  output  1  transmitter can accept a word; high only in TX IDLE.
REQ-011 tx  output  1  serial line out; idle high.
REQ-012 rx  input  1  serial line in; asynchronous to clk.
REQ-013 rx_data  output  DATA_BITS  last received word; held until next rx_valid.
REQ-014 rx_valid  output  1  one-cycle pulse; rx_data and error flags valid.
REQ-015 rx_parity_err  output  1  parity mismatch on the frame flagged by rx_valid.
REQ-016 rx_frame_err  output  1  first stop bit sampled low on the frame flagged by rx_valid.

Function
REQ-017 Tick generator: free-running counter 0..OS_DIV-1; tick = 1 for exactly one clk when counter = OS_DIV-1; shared by TX and RX.
REQ-018 One bit period SHALL equal 16 ticks, for both TX and RX.
REQ-019 TX handshake: word accepted in the cycle where tx_valid && tx_ready; tx_data captured there; later tx_data changes are ignored.
REQ-020 TX states IDLE -> START -> DATA -> PARITY (PARITY_EN only) -> STOP -> IDLE; tx = 0 in START, LSB-first data bits, parity bit, tx = 1 in STOP.
REQ-021 tx goes low in the cycle after acceptance; the first bit may be short by at most one tick period; every later bit lasts exactly 16 ticks.
REQ-022 Parity bit = XOR of data bits, inverted when PARITY_ODD = 1.
REQ-023 STOP lasts STOP_BITS x 16 ticks; tx_ready rises in the cycle after the final stop tick; tx_valid held high gives back-to-back frames with no extra idle.
REQ-024 RX input passes a 2-flop synchronizer before any use; all RX decisions use the synchronized value on tick cycles only.
REQ-025 RX states IDLE -> START -> DATA -> PARITY (PARITY_EN only) -> STOP -> IDLE.
REQ-026 IDLE: synchronized rx = 0 on a tick enters START and clears the tick counter.
REQ-027 START: at the 8th tick rx is re-sampled; 0 -> DATA; 1 -> false start, return to IDLE, no rx_valid.
REQ-028 DATA/PARITY/STOP: one sample every 16 ticks after the start mid-point, shifted LSB-first into DATA_BITS.
REQ-029 RX checks only the first stop bit, even when STOP_BITS = 2.
REQ-030 At the stop mid-sample: update rx_data, set both error flags, pulse rx_valid for 1 clk, return to IDLE in the same cycle.
REQ-031 rx_valid has no backpressure; an unconsumed word is overwritten by the next frame.
REQ-032 Break (line held low): rx_data = 0, rx_frame_err = 1; RX then waits in IDLE until the line returns high before accepting a new start.
REQ-033 TX and RX operate independently and concurrently; external tx->rx loopback SHALL be legal.

Reset
REQ-034 While reset is high: tx = 1, tx_ready = 1, rx_data = 0, rx_valid = 0, both error flags = 0, both FSMs in IDLE, tick counter = 0, synchronizer flops = 1.
REQ-035 Reset mid-frame: tx returns high immediately; the partial TX word is dropped; a partial RX frame never produces rx_valid.

Structure
REQ-036 Package uart_pkg SHALL hold the TX/RX state enums and the constants OVERSAMPLE = 16 and MID_SAMPLE = 8.
REQ-037 Sub-module uart_os_tick SHALL implement the tick generator (parameter OS_DIV).
REQ-038 Illegal parameter values SHALL cause an elaboration-time error.

Verification (OS_DIV = 4)
REQ-039 Loopback 8N1, send 0xA5 -> one rx_valid, rx_data = 0xA5, no errors; tx_ready low for about 640 clk.
REQ-040 PARITY_EN = 1, PARITY_ODD = 1, send 0x03 -> parity bit on tx = 1; inject inverted parity on rx -> rx_parity_err = 1 with rx_valid.
REQ-041 Drive frame 0x55 on rx with stop bit low -> rx_valid, rx_data = 0x55, rx_frame_err = 1.
REQ-042 rx low for 3 ticks then high -> no rx_valid; RX back in IDLE; the next valid frame 0x3C is received correctly.
REQ-043 tx_valid held high with 0x11 then 0x22, STOP_BITS = 2 -> two frames, exactly 32 ticks of stop between them, one tx_ready/tx_valid handshake per word.
REQ-044 Assert reset during TX data bit 3 -> tx = 1 at once, no rx_valid in loopback; the next frame 0x7E completes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and the TX/RX state encodings.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_if.sv
// UART user-side bundle: TX word handshake, RX word/flags and the two serial lines.
interface uart_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_data, tx_valid, rx,
        input  tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid, rx,
        output tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

endinterface

// File: rtl/uart_os_tick.sv
// Free-running 16x oversample tick: one-clk pulse every OS_DIV clocks, shared by TX and RX.
module uart_os_tick #(
    parameter int OS_DIV = 651
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (OS_DIV > 2) ? $clog2(OS_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(OS_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: independent TX and RX state machines paced by a common oversample tick.
module uart_core
    import uart_pkg::*;
#(
    parameter int OS_DIV     = 651,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic  clk,
    input logic  reset,
    uart_if.slave bus
);

    generate
        if (OS_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
            $error("uart_core: illegal parameter value");
        end
    endgenerate

    localparam logic ODD        = (PARITY_ODD != 0);
    localparam logic HAS_PARITY = (PARITY_EN != 0);
    localparam int   STOP_TICKS = STOP_BITS * OVERSAMPLE;

    logic tick;

    uart_os_tick #(.OS_DIV(OS_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic [4:0]           tx_ticks;
    logic [4:0]           tx_last;
    logic [2:0]           tx_bit;

    assign bus.tx_ready = (tx_state == TX_IDLE);
    assign tx_last      = (tx_state == TX_STOP) ? 5'(STOP_TICKS - 1) : 5'(OVERSAMPLE - 1);

    // Each bit ends on the tick that completes its tick budget; the next bit is driven on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_ticks <= '0;
            tx_bit   <= '0;
            bus.tx   <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (bus.tx_valid) begin
                tx_shift <= bus.tx_data;
                tx_par   <= (^bus.tx_data) ^ ODD;
                tx_ticks <= '0;
                tx_state <= TX_START;
                bus.tx   <= 1'b0;
            end
        end else if (tick) begin
            if (tx_ticks != tx_last) begin
                tx_ticks <= tx_ticks + 5'd1;
            end else begin
                tx_ticks <= '0;
                unique case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        bus.tx   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                    TX_DATA: begin
                        if (tx_bit == 3'(DATA_BITS - 1)) begin
                            tx_state <= HAS_PARITY ? TX_PARITY : TX_STOP;
                            bus.tx   <= HAS_PARITY ? tx_par : 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            bus.tx   <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        bus.tx   <= 1'b1;
                    end
                    default: begin
                        tx_state <= TX_IDLE;
                        bus.tx   <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic [1:0]           rx_sync;
    logic                 rx_s;
    rx_state_t            rx_state;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic [3:0]           rx_ticks;
    logic [2:0]           rx_bit;
    logic                 rx_full;
    logic                 wait_high;

    assign rx_s    = rx_sync[1];
    assign rx_full = (rx_ticks == 4'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], bus.rx};
        end
    end

    // After a low stop bit (including a break) the line must return high before a new start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state          <= RX_IDLE;
            rx_shift          <= '0;
            rx_par_bit        <= 1'b0;
            rx_ticks          <= '0;
            rx_bit            <= '0;
            wait_high         <= 1'b0;
            bus.rx_data       <= '0;
            bus.rx_valid      <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (tick) begin
                unique case (rx_state)
                    RX_IDLE: begin
                        if (wait_high) begin
                            if (rx_s) wait_high <= 1'b0;
                        end else if (!rx_s) begin
                            rx_state <= RX_START;
                            rx_ticks <= '0;
                        end
                    end
                    RX_START: begin
                        if (rx_ticks == 4'(MID_SAMPLE - 1)) begin
                            rx_ticks <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_full) begin
                            rx_ticks <= '0;
                            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                            rx_bit   <= rx_bit + 3'd1;
                            if (rx_bit == 3'(DATA_BITS - 1)) begin
                                rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                            end
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_full) begin
                            rx_ticks   <= '0;
                            rx_par_bit <= rx_s;
                            rx_state   <= RX_STOP;
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                    default: begin
                        if (rx_full) begin
                            rx_ticks          <= '0;
                            bus.rx_data       <= rx_shift;
                            bus.rx_parity_err <= HAS_PARITY & ((^rx_shift) ^ ODD ^ rx_par_bit);
                            bus.rx_frame_err  <= !rx_s;
                            wait_high         <= !rx_s;
                            bus.rx_valid      <= 1'b1;
                            rx_state          <= RX_IDLE;
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: an 8N1 instance and an odd-parity two-stop instance at OS_DIV = 4.
module tb_uart_core;

    localparam int OS_DIV   = 4;
    localparam int BIT_CLKS = 16 * OS_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    uart_if #(.DATA_BITS(8)) bus_a ();
    uart_if #(.DATA_BITS(8)) bus_b ();

    logic loop_a   = 1'b0;
    logic loop_b   = 1'b0;
    logic drv      = 1'b1;
    logic target_b = 1'b0;

    assign bus_a.rx = loop_a ? bus_a.tx : (target_b ? 1'b1 : drv);
    assign bus_b.rx = loop_b ? bus_b.tx : (target_b ? drv : 1'b1);

    uart_core #(.OS_DIV(OS_DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    uart_core #(.OS_DIV(OS_DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    rx_exp_t q_a[$];
    rx_exp_t q_b[$];
    rx_exp_t exp_a;
    rx_exp_t exp_b;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        vectors++;
        if (got < lo || got > hi) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Independent oversample tick model, used to measure bit lengths on the b line in ticks.
    int   tick_cnt_m;
    logic tick_m;
    int   run_ticks = 0;
    int   last_run  = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) tick_cnt_m <= 0;
        else       tick_cnt_m <= (tick_cnt_m == OS_DIV - 1) ? 0 : tick_cnt_m + 1;
    end

    assign tick_m = (tick_cnt_m == OS_DIV - 1);

    always @(negedge clk) begin
        if (bus_b.tx) begin
            run_ticks = run_ticks + int'(tick_m);
        end else begin
            if (run_ticks != 0) last_run = run_ticks;
            run_ticks = 0;
        end
    end

    always @(negedge clk) begin
        if (bus_a.rx_valid) begin
            if (q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL rx_a_unexpected: got rx_valid with data %0h, required no rx_valid", bus_a.rx_data);
            end else begin
                exp_a = q_a.pop_front();
                check_output("rx_a_word", {bus_a.rx_data, bus_a.rx_parity_err, bus_a.rx_frame_err}, exp_a);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.rx_valid) begin
            if (q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL rx_b_unexpected: got rx_valid with data %0h, required no rx_valid", bus_b.rx_data);
            end else begin
                exp_b = q_b.pop_front();
                check_output("rx_b_word", {bus_b.rx_data, bus_b.rx_parity_err, bus_b.rx_frame_err}, exp_b);
            end
        end
    end

    task automatic expect_rx(input bit use_b, input logic [7:0] d, input logic perr, input logic ferr);
        rx_exp_t e;
        e = '{data: d, perr: perr, ferr: ferr};
        if (use_b) q_b.push_back(e);
        else       q_a.push_back(e);
    endtask

    task automatic wait_ready(input bit use_b);
        int n = 0;
        while (!(use_b ? bus_b.tx_ready : bus_a.tx_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL tx_ready_timeout: got tx_ready 0 after %0d clk, required 1", n);
        end
    endtask

    // Returns on the falling edge one cycle after the accepting edge.
    task automatic apply_stimulus(input bit use_b, input logic [7:0] d);
        @(negedge clk);
        wait_ready(use_b);
        if (use_b) begin
            bus_b.tx_data  = d;
            bus_b.tx_valid = 1'b1;
        end else begin
            bus_a.tx_data  = d;
            bus_a.tx_valid = 1'b1;
        end
        @(negedge clk);
        bus_a.tx_valid = 1'b0;
        bus_b.tx_valid = 1'b0;
        check_output("tx_start_low", use_b ? bus_b.tx : bus_a.tx, 0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit with_par, input logic par, input logic stop_lvl);
        drv = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drv = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (with_par) begin
            drv = par;
            repeat (BIT_CLKS) @(negedge clk);
        end
        drv = stop_lvl;
        repeat (BIT_CLKS) @(negedge clk);
        drv = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no end of test after 200000 clk, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy;
        int hs;
        int n;

        bus_a.tx_data  = '0;
        bus_a.tx_valid = 1'b0;
        bus_b.tx_data  = '0;
        bus_b.tx_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset_a", {bus_a.tx, bus_a.tx_ready, bus_a.rx_data, bus_a.rx_valid,
                                 bus_a.rx_parity_err, bus_a.rx_frame_err}, 13'h1800);
        check_output("reset_b", {bus_b.tx, bus_b.tx_ready, bus_b.rx_data, bus_b.rx_valid,
                                 bus_b.rx_parity_err, bus_b.rx_frame_err}, 13'h1800);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] loopback 8N1 0xA5");
        loop_a = 1'b1;
        expect_rx(0, 8'hA5, 1'b0, 1'b0);
        apply_stimulus(0, 8'hA5);
        busy = 1;
        while (!bus_a.tx_ready && busy < 2000) begin
            @(negedge clk);
            busy++;
        end
        check_range("tx_busy_clks", busy, 636, 641);
        check_output("tx_idle_high", bus_a.tx, 1);
        repeat (3 * BIT_CLKS) @(negedge clk);

        $display("[TB] framing error 0x55");
        loop_a = 1'b0;
        target_b = 1'b0;
        expect_rx(0, 8'h55, 1'b0, 1'b1);
        drive_frame(8'h55, 0, 1'b0, 1'b0);

        $display("[TB] false start then 0x3C");
        drv = 1'b0;
        repeat (3 * OS_DIV) @(negedge clk);
        drv = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        expect_rx(0, 8'h3C, 1'b0, 1'b0);
        drive_frame(8'h3C, 0, 1'b0, 1'b1);

        $display("[TB] break then 0x96");
        expect_rx(0, 8'h00, 1'b0, 1'b1);
        drv = 1'b0;
        repeat (25 * BIT_CLKS) @(negedge clk);
        drv = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        expect_rx(0, 8'h96, 1'b0, 1'b0);
        drive_frame(8'h96, 0, 1'b0, 1'b1);

        $display("[TB] reset during data bit 3, then 0x7E");
        loop_a = 1'b1;
        apply_stimulus(0, 8'h52);
        repeat (285) @(negedge clk);
        check_output("tx_data_bit3", bus_a.tx, 0);
        reset = 1'b1;
        #1;
        check_output("tx_high_in_reset", {bus_a.tx, bus_a.tx_ready}, 2'b11);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15 * BIT_CLKS) @(negedge clk);
        expect_rx(0, 8'h7E, 1'b0, 1'b0);
        apply_stimulus(0, 8'h7E);
        wait_ready(0);
        repeat (3 * BIT_CLKS) @(negedge clk);

        $display("[TB] odd parity loopback 0x03");
        loop_b = 1'b1;
        expect_rx(1, 8'h03, 1'b0, 1'b0);
        apply_stimulus(1, 8'h03);
        repeat (94) @(negedge clk);
        check_output("tx_b_bit0", bus_b.tx, 1);
        repeat (128) @(negedge clk);
        check_output("tx_b_bit2", bus_b.tx, 0);
        repeat (384) @(negedge clk);
        check_output("tx_b_parity", bus_b.tx, 1);
        repeat (64) @(negedge clk);
        check_output("tx_b_stop", bus_b.tx, 1);
        wait_ready(1);
        repeat (3 * BIT_CLKS) @(negedge clk);

        $display("[TB] injected parity frames");
        loop_b = 1'b0;
        target_b = 1'b1;
        expect_rx(1, 8'h03, 1'b1, 1'b0);
        drive_frame(8'h03, 1, 1'b0, 1'b1);
        expect_rx(1, 8'h80, 1'b0, 1'b0);
        drive_frame(8'h80, 1, 1'b0, 1'b1);
        target_b = 1'b0;

        $display("[TB] back-to-back 0x11 0x22 with two stop bits");
        loop_b = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        expect_rx(1, 8'h11, 1'b0, 1'b0);
        expect_rx(1, 8'h22, 1'b0, 1'b0);
        bus_b.tx_data  = 8'h11;
        bus_b.tx_valid = 1'b1;
        hs = 0;
        n  = 0;
        while (hs < 2 && n < 3000) begin
            if (bus_b.tx_ready) hs++;
            @(negedge clk);
            n++;
            if (hs == 1) bus_b.tx_data = 8'h22;
        end
        bus_b.tx_valid = 1'b0;
        check_output("b2b_handshakes", hs, 2);
        @(negedge clk);
        check_output("b2b_high_ticks", last_run, 48);
        wait_ready(1);
        repeat (4 * BIT_CLKS) @(negedge clk);

        check_output("queue_a_empty", q_a.size(), 0);
        check_output("queue_b_empty", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
